riscv_decode: RTL and testbench
===============================

# riscv_decode

Single-issue RV32I decode/sequencing block. It accepts one 32-bit instruction, reads its source operands from the register file, and presents an ALU operation with two 32-bit operands. It then writes the ALU result back to the register file. It sits between the fetch logic (instruction + ready strobe), a combinational ALU and a register file with asynchronous read.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `instruction_RDY_BSY` in 1: instruction valid strobe; sampled only in IDLE.
- `instruction` in 32: RV32I instruction word.
- `alu_result` in 32: combinational ALU output for the presented operands.
- `alu_opcode` out 8: ALU operation code (package constants).
- `alu_imm1` out 32: ALU operand A.
- `alu_imm2` out 32: ALU operand B.
- `RF_chip_enable` out 1: register-file access enable.
- `RF_write_enable` out 1: 1 = write, 0 = read; meaningful only with chip enable.
- `RF_reg1_data` in 32: rs1 read data; combinational from `RF_rs1_address`.
- `RF_reg2_data` in 32: rs2 read data; combinational from `RF_rs2_address`.
- `RF_rs1_address` out 5: source register 1.
- `RF_rs2_address` out 5: source register 2.
- `RF_WR_add` out 5: destination register for writeback.
- `RF_WriteData` out 32: writeback data.

## Operation
- FSM states are IDLE, READ, EXEC and WB; the sequence is IDLE→READ→EXEC→WB→IDLE.
- **Accepting an instruction.** In IDLE, when `instruction_RDY_BSY`=1 at a clock edge:
  - latch `instruction`;
  - drive `RF_rs1_address`=instr[19:15] and `RF_rs2_address`=instr[24:20];
  - drive `RF_chip_enable`=1 and `RF_write_enable`=0;
  - go to READ.
- **READ.** Register `RF_reg1_data`/`RF_reg2_data` into operand A/B and go to EXEC.
- **EXEC.** Drive `alu_opcode`, `alu_imm1` and `alu_imm2`, which are registered on READ→EXEC. `RF_chip_enable`=0. Capture `alu_result` at the end of the state.
- **WB.** If the instruction is legal and rd≠0, drive `RF_chip_enable`=1, `RF_write_enable`=1, `RF_WR_add`=rd and `RF_WriteData`=captured result for exactly one cycle. Otherwise `RF_chip_enable`=0.
- **Decode rules:**
  - 0110011 (R-type): A=rs1 data, B=rs2 data. funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0x20 selects SUB (funct3=000) or SRA (funct3=101). Any other funct7 is illegal.
  - 0010011 (I-type ALU): A=rs1 data, B=sign-extended instr[31:20].
    - SLLI/SRLI/SRAI use B={27'b0, instr[24:20]}; funct7=0x20 selects SRAI.
    - SLLI with funct7≠0 is illegal.
    - SRLI/SRAI with funct7 other than 0x00/0x20 are illegal.
  - 0110111 (LUI): A=0, B={instr[31:12],12'b0}, op ADD.
  - Any other opcode is illegal: `alu_opcode`=NOP (0xFF), A=B=0, no write.
- **ALU codes:** ADD 0x00, SUB 0x01, SLL 0x02, SLT 0x03, SLTU 0x04, XOR 0x05, SRL 0x06, SRA 0x07, OR 0x08, AND 0x09, NOP 0xFF.
- `instruction_RDY_BSY` is ignored outside IDLE. There is no back-pressure output.
- **Output holding.** ALU and RF address outputs hold their last value until next updated. `RF_write_enable` returns to 0 when leaving WB.

## Timing
- **Reset.** While `rst`=0: state IDLE, all outputs 0. This includes `alu_opcode`=0x00, both enables 0 and all addresses 0.
- **Reset mid-operation.** The instruction is abandoned immediately and no write occurs.
- **Latency.** Accept edge at t0. READ during t0→t1. EXEC during t1→t2. WB during t2→t3. Back in IDLE at t3.
- **Throughput.** One instruction per 4 cycles. A strobe held high continuously re-accepts the current `instruction` at every IDLE edge.
- **Same-cycle requirements.** `RF_reg*_data` must be valid within the READ cycle. `alu_result` must be valid within the EXEC cycle.

## Structure
- A shared package holds:
  - opcode constants (OP_R=7'b0110011, OP_I=7'b0010011, OP_LUI=7'b0110111);
  - ALU operation codes;
  - the FSM state enum.
- One natural sub-module, `decode_fields`: purely combinational instruction→{rs1, rs2, rd, alu op, imm, use_imm, zero_a, legal, wr_en}. The top level keeps the FSM and output registers.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles → all outputs 0 and state IDLE. Release and keep the strobe low for 5 cycles → outputs unchanged.
- **ADDI.** Send 0x00308113 (addi x2,x1,3) with x1=5. Required response:
  - READ: rs1=1, CE=1, WE=0;
  - EXEC: op 0x00, A=5, B=3;
  - with `alu_result`=8, WB: CE=1, WE=1, WR_add=2, WriteData=8.
- **SUB.** Send 0x40208033 (sub x0,x1,x2), rd=x0 → op 0x01 in EXEC, no write in WB (CE=0).
- **Sign extension.** Send 0xFFF0A193 (slti x3,x1,-1) → B=0xFFFFFFFF, op 0x03. Send 0x4050D213 (srai x4,x1,5) → B=5, op 0x07.
- **LUI and illegal.** Send 0x123452B7 (lui x5) → A=0, B=0x12345000, write to x5. Send 0x0000006F (jal) → op 0xFF, no write.
- **Reset during EXEC.** Assert reset during EXEC → outputs 0 immediately, no write. After release, the next instruction completes normally.

Source files
------------

// File: rtl/riscv_decode_pkg.sv
// Shared constants, FSM state type and decoded-instruction record for riscv_decode.
package riscv_decode_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] F7_ALT = 7'h20;

    localparam logic [7:0] ALU_ADD  = 8'h00;
    localparam logic [7:0] ALU_SUB  = 8'h01;
    localparam logic [7:0] ALU_SLL  = 8'h02;
    localparam logic [7:0] ALU_SLT  = 8'h03;
    localparam logic [7:0] ALU_SLTU = 8'h04;
    localparam logic [7:0] ALU_XOR  = 8'h05;
    localparam logic [7:0] ALU_SRL  = 8'h06;
    localparam logic [7:0] ALU_SRA  = 8'h07;
    localparam logic [7:0] ALU_OR   = 8'h08;
    localparam logic [7:0] ALU_AND  = 8'h09;
    localparam logic [7:0] ALU_NOP  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  op;
        logic [31:0] imm;
        logic        use_imm;
        logic        zero_a;
        logic        legal;
        logic        wr_en;
    } decode_t;

    // funct3 -> operation for the base (funct7 = 0) encodings.
    function automatic logic [7:0] base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_decode_fields.sv
// Purely combinational RV32I field extraction and ALU-op / immediate decode.
module decode_fields
    import riscv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec         = '0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.op      = ALU_NOP;
        case (instr[6:0])
            OP_R: begin
                if (funct7 == 7'h00) begin
                    dec.legal = 1'b1;
                    dec.op    = base_op(funct3);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec.legal = 1'b1;
                    dec.op    = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
            end
            OP_I: begin
                dec.use_imm = 1'b1;
                case (funct3)
                    3'b001: begin
                        dec.imm = {27'b0, instr[24:20]};
                        if (funct7 == 7'h00) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SLL;
                        end
                    end
                    3'b101: begin
                        dec.imm = {27'b0, instr[24:20]};
                        if (funct7 == 7'h00) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SRA;
                        end
                    end
                    default: begin
                        dec.imm   = {{20{instr[31]}}, instr[31:20]};
                        dec.legal = 1'b1;
                        dec.op    = base_op(funct3);
                    end
                endcase
            end
            OP_LUI: begin
                dec.legal   = 1'b1;
                dec.op      = ALU_ADD;
                dec.zero_a  = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = {instr[31:12], 12'b0};
            end
            default: ;
        endcase
        dec.wr_en = dec.legal && (dec.rd != 5'd0);
    end

endmodule

// File: rtl/riscv_decode.sv
// Four-state RV32I decode sequencer: accept, read operands, execute, write back.
module riscv_decode
    import riscv_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_RDY_BSY,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    output logic [7:0]  alu_opcode,
    output logic [31:0] alu_imm1,
    output logic [31:0] alu_imm2,
    output logic        RF_chip_enable,
    output logic        RF_write_enable,
    input  logic [31:0] RF_reg1_data,
    input  logic [31:0] RF_reg2_data,
    output logic [4:0]  RF_rs1_address,
    output logic [4:0]  RF_rs2_address,
    output logic [4:0]  RF_WR_add,
    output logic [31:0] RF_WriteData,
    output state_t      fsm_state
);

    // Handshake: instruction_RDY_BSY is a valid strobe with no ready return;
    // it is sampled only in IDLE, and a held strobe re-accepts every 4 cycles.
    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [31:0] dec_in;
    decode_t     dec;
    logic        accept, load_ops, capture, wb_done;

    // In IDLE the decoder sees the incoming word so the source addresses load on accept.
    assign dec_in = (state == IDLE) ? instruction : instr_q;

    decode_fields u_decode_fields (
        .instr (dec_in),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instruction_RDY_BSY) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == IDLE) && instruction_RDY_BSY;
        load_ops  = (state == READ);
        capture   = (state == EXEC);
        wb_done   = (state == WB);
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q         <= '0;
            alu_opcode      <= '0;
            alu_imm1        <= '0;
            alu_imm2        <= '0;
            RF_chip_enable  <= 1'b0;
            RF_write_enable <= 1'b0;
            RF_rs1_address  <= '0;
            RF_rs2_address  <= '0;
            RF_WR_add       <= '0;
            RF_WriteData    <= '0;
        end else begin
            if (accept) begin
                instr_q         <= instruction;
                RF_rs1_address  <= dec.rs1;
                RF_rs2_address  <= dec.rs2;
                RF_chip_enable  <= 1'b1;
                RF_write_enable <= 1'b0;
            end
            if (load_ops) begin
                alu_opcode     <= dec.op;
                alu_imm1       <= (dec.legal && !dec.zero_a) ? RF_reg1_data : 32'd0;
                alu_imm2       <= !dec.legal ? 32'd0 : (dec.use_imm ? dec.imm : RF_reg2_data);
                RF_chip_enable <= 1'b0;
            end
            if (capture) begin
                RF_WriteData <= alu_result;
                if (dec.wr_en) begin
                    RF_chip_enable  <= 1'b1;
                    RF_write_enable <= 1'b1;
                    RF_WR_add       <= dec.rd;
                end else begin
                    RF_chip_enable  <= 1'b0;
                end
            end
            if (wb_done) begin
                RF_chip_enable  <= 1'b0;
                RF_write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_decode.sv
// Self-checking bench for riscv_decode with a register-file and ALU model.
module tb_riscv_decode;
    import riscv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instruction_RDY_BSY;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [7:0]  alu_opcode;
    logic [31:0] alu_imm1, alu_imm2;
    logic        RF_chip_enable, RF_write_enable;
    logic [31:0] RF_reg1_data, RF_reg2_data;
    logic [4:0]  RF_rs1_address, RF_rs2_address, RF_WR_add;
    logic [31:0] RF_WriteData;
    state_t      fsm_state;

    logic [31:0] rf [32];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_decode dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_RDY_BSY (instruction_RDY_BSY),
        .instruction         (instruction),
        .alu_result          (alu_result),
        .alu_opcode          (alu_opcode),
        .alu_imm1            (alu_imm1),
        .alu_imm2            (alu_imm2),
        .RF_chip_enable      (RF_chip_enable),
        .RF_write_enable     (RF_write_enable),
        .RF_reg1_data        (RF_reg1_data),
        .RF_reg2_data        (RF_reg2_data),
        .RF_rs1_address      (RF_rs1_address),
        .RF_rs2_address      (RF_rs2_address),
        .RF_WR_add           (RF_WR_add),
        .RF_WriteData        (RF_WriteData),
        .fsm_state           (fsm_state)
    );

    assign RF_reg1_data = rf[RF_rs1_address];
    assign RF_reg2_data = rf[RF_rs2_address];
    assign alu_result   = alu_model(alu_opcode, alu_imm1, alu_imm2);

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            8'h00:   return a + b;
            8'h01:   return a - b;
            8'h02:   return a << b[4:0];
            8'h03:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8'h04:   return (a < b) ? 32'd1 : 32'd0;
            8'h05:   return a ^ b;
            8'h06:   return a >> b[4:0];
            8'h07:   return $unsigned($signed(a) >>> b[4:0]);
            8'h08:   return a | b;
            8'h09:   return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic void ref_model(input logic [31:0] ins, output logic [7:0] op,
                                      output logic [31:0] a, output logic [31:0] b, output bit wr);
        logic [7:0] by_f3 [8];
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal;
        by_f3 = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09};
        f3 = ins[14:12];
        f7 = ins[31:25];
        op = 8'hFF; a = 32'd0; b = 32'd0; legal = 0;
        if (ins[6:0] == 7'b0110011) begin
            a = rf[ins[19:15]]; b = rf[ins[24:20]];
            if (f7 == 7'h00) begin legal = 1; op = by_f3[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; op = 8'h01; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; op = 8'h07; end
        end else if (ins[6:0] == 7'b0010011) begin
            a = rf[ins[19:15]];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = 32'(ins[24:20]);
                if (f7 == 7'h00) begin legal = 1; op = by_f3[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; op = 8'h07; end
            end else begin
                b = 32'($signed(ins[31:20]));
                legal = 1; op = by_f3[f3];
            end
        end else if (ins[6:0] == 7'b0110111) begin
            legal = 1; op = 8'h00; b = ins & 32'hFFFFF000;
        end
        if (!legal) begin op = 8'hFF; a = 32'd0; b = 32'd0; end
        wr = legal && (ins[11:7] != 5'd0);
    endfunction

    // Runs one instruction from an IDLE negedge to the IDLE negedge after WB.
    task automatic run_instr(input string name, input logic [31:0] ins, input bit hold,
                             input logic [7:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                             input bit e_wr, input logic [31:0] e_data);
        instruction = ins;
        instruction_RDY_BSY = 1'b1;
        @(negedge clk);
        if (!hold) instruction_RDY_BSY = 1'b0;
        n_checks++;
        if ({fsm_state == READ, RF_rs1_address, RF_rs2_address, RF_chip_enable, RF_write_enable}
            !== {1'b1, ins[19:15], ins[24:20], 2'b10}) begin
            n_fail++;
            $display("FAIL %s read: st=%0d rs1=%0d rs2=%0d ce=%b we=%b, want rs1=%0d rs2=%0d ce=1 we=0",
                     name, fsm_state, RF_rs1_address, RF_rs2_address, RF_chip_enable, RF_write_enable,
                     ins[19:15], ins[24:20]);
        end
        @(negedge clk);
        n_checks++;
        if ({alu_opcode, alu_imm1, alu_imm2, RF_chip_enable} !== {e_op, e_a, e_b, 1'b0}) begin
            n_fail++;
            $display("FAIL %s exec: op=%h a=%h b=%h ce=%b, want op=%h a=%h b=%h ce=0",
                     name, alu_opcode, alu_imm1, alu_imm2, RF_chip_enable, e_op, e_a, e_b);
        end
        @(negedge clk);
        n_checks++;
        if (e_wr) begin
            if ({RF_chip_enable, RF_write_enable, RF_WR_add, RF_WriteData} !== {2'b11, ins[11:7], e_data}) begin
                n_fail++;
                $display("FAIL %s wb: ce=%b we=%b rd=%0d data=%h, want ce=1 we=1 rd=%0d data=%h",
                         name, RF_chip_enable, RF_write_enable, RF_WR_add, RF_WriteData, ins[11:7], e_data);
            end
        end else if (RF_chip_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wb: ce=%b, want ce=0 (no write)", name, RF_chip_enable);
        end
        @(negedge clk);
        n_checks++;
        if ({fsm_state == IDLE, RF_chip_enable, RF_write_enable} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s idle: st=%0d ce=%b we=%b, want st=IDLE ce=0 we=0",
                     name, fsm_state, RF_chip_enable, RF_write_enable);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [120:0] outs;
        outs = {alu_opcode, alu_imm1, alu_imm2, RF_chip_enable, RF_write_enable,
                RF_rs1_address, RF_rs2_address, RF_WR_add, RF_WriteData};
        n_checks++;
        if (outs !== 121'd0 || fsm_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s: outputs=%h st=%0d, want all zero and IDLE", name, outs, fsm_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        instruction_RDY_BSY = 1'b0;
        instruction = $urandom;
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_all_zero("reset_idle");
        end
    endtask

    task automatic test_addi();
        rf[1] = 32'd5; rf[2] = 32'd7;
        run_instr("addi", 32'h00308113, 1'b0, 8'h00, 32'd5, 32'd3, 1'b1, 32'd8);
    endtask

    task automatic test_sub();
        run_instr("sub_x0", 32'h40208033, 1'b0, 8'h01, 32'd5, 32'd7, 1'b0, 32'd0);
    endtask

    task automatic test_sign_ext();
        run_instr("slti", 32'hFFF0A193, 1'b0, 8'h03, 32'd5, 32'hFFFFFFFF, 1'b1, 32'd0);
        run_instr("srai", 32'h4050D213, 1'b0, 8'h07, 32'd5, 32'd5, 1'b1, 32'd0);
    endtask

    task automatic test_lui_illegal();
        run_instr("lui", 32'h123452B7, 1'b0, 8'h00, 32'd0, 32'h12345000, 1'b1, 32'h12345000);
        run_instr("jal", 32'h0000006F, 1'b0, 8'hFF, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset_exec();
        instruction = 32'h00308113;
        instruction_RDY_BSY = 1'b1;
        @(negedge clk);
        instruction_RDY_BSY = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset_in_exec");
        @(negedge clk);
        check_all_zero("reset_no_write");
        rst = 1'b1;
        rf[1] = 32'd5;
        run_instr("after_reset", 32'h00308113, 1'b0, 8'h00, 32'd5, 32'd3, 1'b1, 32'd8);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic [7:0] op;
        logic [31:0] a, b;
        bit wr;
        for (int i = 0; i < 4; i++) begin
            ins = {12'($urandom), 5'($urandom), 3'd0, 5'($urandom_range(1, 31)), 7'b0010011};
            ref_model(ins, op, a, b, wr);
            run_instr("back_to_back", ins, i != 3, op, a, b, wr, alu_model(op, a, b));
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [7:0] op;
        logic [31:0] a, b;
        bit wr;
        for (int i = 0; i < 40; i++) begin
            for (int r = 1; r < 32; r++) rf[r] = $urandom;
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'b0110011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0110111;
                default: ins[6:0] = 7'b1100011;
            endcase
            case ($urandom_range(0, 2))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
            ref_model(ins, op, a, b, wr);
            run_instr("random", ins, 1'b0, op, a, b, wr, alu_model(op, a, b));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : $urandom;
        test_reset();
        test_addi();
        test_sub();
        test_sign_ext();
        test_lui_illegal();
        test_reset_exec();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
